// File: rtl/cmos_xor3.sv
// Three-input odd-parity cell built from CMOS switch primitives,
// with a registered copy of the result for synchronous consumers.
module cmos_xor3 (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic out,
  output logic out_q
);

  supply1 vdd;
  supply0 gnd;

  wire a_n;
  wire b_n;
  wire c_n;
  wire x;
  wire x_n;
  wire y_n;
  wire out_w;

  // input inverters
  pmos pa (a_n, vdd, a);
  nmos na (a_n, gnd, a);

  pmos pb (b_n, vdd, b);
  nmos nb (b_n, gnd, b);

  pmos pc (c_n, vdd, c);
  nmos nc (c_n, gnd, c);

  // x = a ? b_n : b, each leg a full transmission gate
  nmos t0n (x, b_n, a);
  pmos t0p (x, b_n, a_n);
  nmos t1n (x, b,   a_n);
  pmos t1p (x, b,   a);

  // restore and complement x
  pmos px (x_n, vdd, x);
  nmos nx (x_n, gnd, x);

  // y_n = c ? x : x_n, which is the complement of x ^ c
  nmos t2n (y_n, x,   c);
  pmos t2p (y_n, x,   c_n);
  nmos t3n (y_n, x_n, c_n);
  pmos t3p (y_n, x_n, c);

  // restoring output inverter
  pmos py (out_w, vdd, y_n);
  nmos ny (out_w, gnd, y_n);

  assign out = out_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_cmos_xor3.sv
// Bench for cmos_xor3: directed scenarios plus random
// stimulus against a counting parity model.
module tb_cmos_xor3;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic c;
  logic out;
  logic out_q;

  int n_chk;
  int n_fail;

  cmos_xor3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic parity(input logic [2:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < 3; i++) begin
      if (v[i] == 1'b1) ones = ones + 1;
    end
    return (ones % 2 == 1) ? 1'b1 : 1'b0;
  endfunction

  task automatic drive(input logic [2:0] v);
    a = v[2];
    b = v[1];
    c = v[0];
  endtask

  task automatic test_reset();
    logic [2:0] v;
    v = 3'b110;
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (out_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_q got %b want 0", out_q);
    end
    n_chk++;
    if (out !== parity(v)) begin
      n_fail++;
      $display("FAIL reset_out got %b want %b", out, parity(v));
    end
  endtask

  task automatic test_truth_table();
    logic [2:0] v;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      drive(v);
      #0;
      #0;
      n_chk++;
      if (out !== parity(v)) begin
        n_fail++;
        $display("FAIL truth_%b got %b want %b", v, out, parity(v));
      end
      #5;
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    drive(3'b011);
    @(posedge clk);
    #1;
    n_chk++;
    if (out_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_first got %b want 0", out_q);
    end
    @(negedge clk);
    drive(3'b111);
    #1;
    n_chk++;
    if (out_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_hold got %b want 0", out_q);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (out_q !== 1'b1) begin
      n_fail++;
      $display("FAIL reg_second got %b want 1", out_q);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(3'b100);
    @(posedge clk);
    #1;
    n_chk++;
    if (out_q !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre got %b want 1", out_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_q !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_q got %b want 0", out_q);
    end
    n_chk++;
    if (out !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_out got %b want 1", out);
    end
  endtask

  task automatic test_reset_hold();
    drive(3'b001);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (out_q !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d got %b want 0", i, out_q);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (out_q !== 1'b0) begin
      n_fail++;
      $display("FAIL release_pre got %b want 0", out_q);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (out_q !== 1'b1) begin
      n_fail++;
      $display("FAIL release_cap got %b want 1", out_q);
    end
  endtask

  task automatic test_toggle();
    logic [2:0] seq [6];
    logic       prev;
    seq = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001};
    drive(seq[0]);
    #1;
    prev = out;
    n_chk++;
    if (prev !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_start got %b want 0", prev);
    end
    for (int i = 1; i < 6; i++) begin
      drive(seq[i]);
      #1;
      n_chk++;
      if (out !== parity(seq[i]) || out === prev) begin
        n_fail++;
        $display("FAIL toggle_%b got %b want %b", seq[i], out,
                 parity(seq[i]));
      end
      prev = out;
    end
  endtask

  task automatic test_random();
    logic       pend [$];
    logic [2:0] v;
    logic       exp_q;
    pend.delete();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      v = 3'($urandom_range(0, 7));
      drive(v);
      #1;
      n_chk++;
      if (out !== parity(v)) begin
        n_fail++;
        $display("FAIL rand_out %b got %b want %b", v, out, parity(v));
      end
      pend.push_back(parity(v));
      @(posedge clk);
      #1;
      exp_q = pend.pop_front();
      n_chk++;
      if (out_q !== exp_q) begin
        n_fail++;
        $display("FAIL rand_q %b got %b want %b", v, out_q, exp_q);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    a      = 1'b0;
    b      = 1'b0;
    c      = 1'b0;
    test_reset();
    test_truth_table();
    test_registered();
    test_async_reset();
    test_reset_hold();
    test_toggle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmos_xor3.md
Name: cmos_xor3

Overview:
- Three-input XOR (odd parity) gate built at transistor level from CMOS switch primitives (pmos/nmos, supply1/supply0 rails). No behavioural "^" operator is used for the core.
- Provides a combinational output `out` plus a registered copy `out_q` for synchronous consumers.
- Used as a leaf parity/sum cell, for example the sum bit of a full adder.

Parameters:
- None. Width is fixed at 1 bit per input.

Ports:
- clk    input   1  rising-edge clock for the output register
- rst_n  input   1  asynchronous active-low reset, clears out_q
- a      input   1  data input
- b      input   1  data input
- c      input   1  data input
- out    output  1  combinational a XOR b XOR c
- out_q  output  1  registered out

Behaviour:
- Core function: out = 1 when an odd number of a, b, c are 1, otherwise 0.
  - Truth table, abc -> out: 000->0, 001->1, 010->1, 011->0, 100->1, 101->0, 110->0, 111->1.
- Core structure: strictly complementary CMOS.
  - Local inverters produce a_n, b_n, c_n.
  - First stage: static CMOS XOR2 of a, b gives x, plus its complement x_n.
  - Second stage: static CMOS XOR2 of x, c drives out.
  - Every pull-up network is the dual of its pull-down network.
  - Exactly one network conducts for every input combination, so `out` never floats (z) or fights (x) with 0/1 inputs.
  - Equivalent single-stage complex-gate or transmission-gate implementations are acceptable if they are fully static and restoring.
- Timing:
  - `out` has zero clock latency and follows any input change within the same simulation time step (primitive delays 0).
  - `out` is independent of clk and rst_n, including while reset is asserted.
- Register:
  - On rst_n falling edge, or whenever rst_n=0: out_q=0 immediately, without waiting for a clock edge.
  - On clk rising edge with rst_n=1: out_q <= current out.
  - Latency from input to out_q is 1 clock.
  - When reset release and a clock edge coincide, reset wins for that edge; capture resumes on the next rising edge with rst_n=1.
- Reset values:
  - out_q = 0.
  - `out` has no reset value; it always reflects the inputs.
- Unknown inputs: any x/z on a, b or c may yield x on `out`; no other requirement. out_q is 0 during reset regardless of inputs.

Test Plan:
1. Exhaustive truth table.
   - Stimulus: rst_n=1; apply abc = 000, 001, 010, 011, 100, 101, 110, 111 at 5-time-unit intervals.
   - Required: out = 0, 1, 1, 0, 1, 0, 0, 1 respectively, each within the same step; never x or z.
2. Registered path.
   - Stimulus: clk period 10; abc=011 then 111 on successive cycles.
   - Required: out_q = 0 after the first edge and 1 after the second, one cycle behind `out`.
3. Asynchronous reset.
   - Stimulus: out_q=1 (abc=100 captured); drop rst_n mid-cycle.
   - Required: out_q=0 at once, with no clock edge needed; `out` stays 1.
4. Reset hold and release.
   - Stimulus: keep rst_n=0 across three clk edges with abc=001, then release rst_n.
   - Required: out_q stays 0 during reset and becomes 1 on the first rising edge after release.
5. Single-bit toggling.
   - Stimulus: from abc=000, toggle each input in turn (100, 110, 111, 011, 001).
   - Required: out flips on every change (1, 0, 1, 0, 1), confirming odd-parity behaviour and no contention.
